// File: rtl/cmp_swap_ram.sv
// cmp_swap_ram: register-file RAM with a host port and a compare-and-swap engine on adjacent words.
module cmp_swap_ram #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              cs_start,
  input  logic [ADDR_W-1:0] cs_addr,
  output logic              busy,
  output logic              cs_done,
  output logic              cs_swapped
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_val, b_val;
  logic [ADDR_W-1:0] a_q, a_nxt;
  logic top, swap;
  assign a_nxt = a_q + 1'b1;
  // the last word has no upper neighbour, so the pair is treated as absent
  assign top = &a_q;
  assign swap = !top && (DESCEND ? a_val < b_val : a_val > b_val);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cs_done    <= 1'b0;
      cs_swapped <= 1'b0;
      data_out   <= '0;
      a_val      <= '0;
      b_val      <= '0;
      a_q        <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cs_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_start) begin
            a_q   <= cs_addr;
            state <= READ;
          end else if (en && we) mem[addr] <= data_in;
          else if (en) data_out <= mem[addr];
        end
        READ: begin
          if (!top) begin
            a_val <= mem[a_q];
            b_val <= mem[a_nxt];
          end
          state <= WRITE;
        end
        WRITE: begin
          if (swap) begin
            mem[a_q]  <= b_val;
            mem[a_nxt] <= a_val;
          end
          cs_swapped <= swap;
          cs_done    <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_swap_ram.sv
// tb_cmp_swap_ram: directed bench comparing ascending and descending builds against a behavioural model.
module tb_cmp_swap_ram;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, we = 1'b0, cs_start = 1'b0;
  logic [3:0] addr = '0, cs_addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] do0, do1;
  logic b0, b1, d0, d1, s0, s1;
  logic [15:0] em [2][16];
  logic [15:0] edo [2];
  logic esw [2], pend [2];
  logic [15:0] x, y;
  int cnt = 0, n_cmp = 0, n_err = 0;

  cmp_swap_ram #(.DATA_W(16), .ADDR_W(4), .DESCEND(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_in(data_in),
    .data_out(do0), .cs_start(cs_start), .cs_addr(cs_addr), .busy(b0),
    .cs_done(d0), .cs_swapped(s0));
  cmp_swap_ram #(.DATA_W(16), .ADDR_W(4), .DESCEND(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_in(data_in),
    .data_out(do1), .cs_start(cs_start), .cs_addr(cs_addr), .busy(b1),
    .cs_done(d1), .cs_swapped(s1));

  always #5 clk = ~clk;

  // Model: a compare-swap resolves at acceptance; its effects stay hidden until the host can look again.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 16; i++) em[d][i] = '0;
        edo[d] = '0;
        esw[d] = 1'b0;
        pend[d] = 1'b0;
      end
      cnt = 0;
    end else if (cnt > 0) begin
      if (cnt == 2) for (int d = 0; d < 2; d++) esw[d] = pend[d];
      cnt--;
    end else if (cs_start) begin
      cnt = 3;
      for (int d = 0; d < 2; d++) begin
        int a;
        a = int'(cs_addr);
        pend[d] = 1'b0;
        if (a != 15) begin
          x = em[d][a];
          y = em[d][a+1];
          pend[d] = (d == 1) ? (x < y) : (x > y);
          if (pend[d]) begin
            em[d][a] = y;
            em[d][a+1] = x;
          end
        end
      end
    end else if (en) begin
      for (int d = 0; d < 2; d++)
        if (we) em[d][addr] = data_in;
        else edo[d] = em[d][addr];
    end
  end

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("data_out0", do0, edo[0]);
    chk("data_out1", do1, edo[1]);
    chk("busy0", {15'b0, b0}, {15'b0, cnt != 0});
    chk("busy1", {15'b0, b1}, {15'b0, cnt != 0});
    chk("cs_done0", {15'b0, d0}, {15'b0, cnt == 1});
    chk("cs_done1", {15'b0, d1}, {15'b0, cnt == 1});
    chk("cs_swapped0", {15'b0, s0}, {15'b0, esw[0]});
    chk("cs_swapped1", {15'b0, s1}, {15'b0, esw[1]});
  end

  task automatic both(input string n, input logic [15:0] act, input logic [15:0] mdl, input logic [15:0] exp);
    chk({n, "_model"}, mdl, exp);
    chk({n, "_dut"}, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    en = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    en = 1'b1; we = 1'b0; addr = a;
    tick;
    en = 1'b0;
  endtask

  task automatic cs(input logic [3:0] a);
    cs_start = 1'b1; cs_addr = a;
    tick;
    cs_start = 1'b0;
    repeat (3) tick;
  endtask

  initial begin
    repeat (2) tick;
    both("reset_dout", do0, edo[0], 16'h0000);
    rst = 1'b0;
    // ascending swap of 5,2
    wr(3, 16'h0005); wr(4, 16'h0002); cs(3);
    both("swap_flag0", {15'b0, s0}, {15'b0, esw[0]}, 16'h0001);
    both("swap_flag1", {15'b0, s1}, {15'b0, esw[1]}, 16'h0000);
    rd(3); both("rd3_after_swap", do0, edo[0], 16'h0002);
    rd(4); both("rd4_after_swap", do0, edo[0], 16'h0005);
    // already ordered, then equal values
    cs(3);
    both("ordered_flag0", {15'b0, s0}, {15'b0, esw[0]}, 16'h0000);
    rd(3); both("rd3_ordered", do0, edo[0], 16'h0002);
    wr(3, 16'h0007); wr(4, 16'h0007); cs(3);
    both("equal_flag0", {15'b0, s0}, {15'b0, esw[0]}, 16'h0000);
    both("equal_flag1", {15'b0, s1}, {15'b0, esw[1]}, 16'h0000);
    // descending build, unsigned compare
    wr(0, 16'h0001); wr(1, 16'hFFFF); cs(0);
    both("desc_flag1", {15'b0, s1}, {15'b0, esw[1]}, 16'h0001);
    rd(0); both("desc_rd0", do1, edo[1], 16'hFFFF);
    rd(1); both("desc_rd1", do1, edo[1], 16'h0001);
    // top address has no neighbour
    wr(15, 16'h0009); wr(0, 16'h0001); cs(15);
    both("top_flag0", {15'b0, s0}, {15'b0, esw[0]}, 16'h0000);
    rd(15); both("top_rd15", do0, edo[0], 16'h0009);
    rd(0); both("top_rd0", do0, edo[0], 16'h0001);
    // host write collides with start, then start repeated while busy
    en = 1'b1; we = 1'b1; addr = 2; data_in = 16'hAAAA; cs_start = 1'b1; cs_addr = 5;
    tick;
    en = 1'b0; we = 1'b0;
    repeat (2) tick;
    cs_start = 1'b0;
    tick;
    tick;
    rd(2); both("dropped_write", do0, edo[0], 16'h0000);
    // reset during WRITE of a swapping pair
    wr(5, 16'h0009); wr(6, 16'h0003); rd(5);
    both("pre_reset_rd5", do0, edo[0], 16'h0009);
    cs_start = 1'b1; cs_addr = 5;
    tick;
    cs_start = 1'b0;
    tick;
    #1 rst = 1'b1;
    #1;
    both("reset_busy", {15'b0, b0}, {15'b0, cnt != 0}, 16'h0000);
    both("reset_dout_mid", do0, edo[0], 16'h0000);
    @(posedge clk);
    #2 rst = 1'b0;
    rd(5); both("reset_rd5", do0, edo[0], 16'h0000);
    rd(6); both("reset_rd6", do0, edo[0], 16'h0000);
    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmp_swap_ram.md
CMP_SWAP_RAM -- requirements
Module: cmp_swap_ram

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words exactly.
REQ-003 Parameter DESCEND, default 0; 0 = ascending order, 1 = descending order.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  host access enable.
REQ-007 we  in  1  host access type: 1 = write, 0 = read.
REQ-008 addr  in  ADDR_W  host address.
REQ-009 data_in  in  DATA_W  host write data.
REQ-010 data_out  out  DATA_W  registered host read data.
REQ-011 cs_start  in  1  compare-swap request, sampled in IDLE only.
REQ-012 cs_addr  in  ADDR_W  lower address a of the pair (a, a+1).
REQ-013 busy  out  1  high while the compare-swap FSM is not in IDLE.
REQ-014 cs_done  out  1  one-cycle pulse at compare-swap completion.
REQ-015 cs_swapped  out  1  result flag: pair was exchanged.

Function
REQ-016 Host write: en=1, we=1, FSM in IDLE, cs_start=0 -> mem[addr] <= data_in at that edge.
REQ-017 Host read: en=1, we=0, FSM in IDLE, cs_start=0 -> data_out <= mem[addr]; valid one cycle after the request edge.
REQ-018 en=0 -> data_out holds its last value; output never driven to Z.
REQ-019 Host requests while busy=1 are ignored: no write, data_out held.
REQ-020 cs_start=1 with en=1 in the same IDLE cycle -> cs_start wins; host request dropped.
REQ-021 FSM states: IDLE, READ, WRITE, DONE; cs_start=1 in IDLE -> READ, latching cs_addr.
REQ-022 READ: capture A = mem[a], B = mem[a+1] into internal registers; next state WRITE.
REQ-023 Swap condition: DESCEND=0 -> A > B; DESCEND=1 -> A < B; unsigned compare; A == B never swaps.
REQ-024 WRITE: if swap, mem[a] <= B and mem[a+1] <= A at the same edge; otherwise no write; next state DONE.
REQ-025 Boundary: a = DEPTH-1 (no upper neighbour) -> no read pair, no write, no wrap to address 0; FSM still runs READ->WRITE->DONE; cs_swapped=0.
REQ-026 DONE: cs_done=1 for exactly one cycle; next state IDLE.
REQ-027 Timing: start sampled at edge N -> busy=1 in cycles N+1..N+3, cs_done=1 in cycle N+3, busy=0 from N+4; new cs_start accepted at edge N+4.
REQ-028 cs_swapped updates at entry to DONE and holds until the next DONE or reset.
REQ-029 cs_start while busy=1 is ignored; no queuing.

Reset
REQ-030 rst=1 -> immediately: FSM IDLE, busy=0, cs_done=0, cs_swapped=0, data_out=0, all DEPTH words=0, A/B registers=0.
REQ-031 rst asserted mid compare-swap -> operation aborted; no partial write survives; all REQ-030 values apply.
REQ-032 First host or cs_start request honoured on the first rising edge with rst=0.

Verification
REQ-033 Write 0x0005 @3, 0x0002 @4; cs_start a=3 -> busy 3 cycles, cs_done pulse, cs_swapped=1; reads @3=0x0002, @4=0x0005.
REQ-034 mem[3]=0x0002, mem[4]=0x0005, cs_start a=3 (DESCEND=0) -> cs_swapped=0, contents unchanged; repeat with equal values 0x0007 -> no swap.
REQ-035 DESCEND=1 build, mem[0]=0x0001, mem[1]=0xFFFF, cs_start a=0 -> swapped; @0=0xFFFF, @1=0x0001 (unsigned compare).
REQ-036 cs_start a=15 (ADDR_W=4), mem[15]=0x0009, mem[0]=0x0001 -> cs_done pulse, cs_swapped=0, @15 and @0 unchanged.
REQ-037 Host write 0xAAAA @2 and cs_start on the same edge, plus cs_start during busy -> write dropped, second start ignored, single cs_done.
REQ-038 rst pulse during WRITE state of a swapping pair -> busy=0, data_out=0, both words read back 0x0000.
